// File: rtl/static_priority_arbiter.sv
// -----------------------------------------------------------------------------
// static_priority_arbiter
// Purely combinational fixed-priority arbiter: the lowest-index asserted
// request wins.
//
// Ports:
//   requests  in  SIZE  candidate request vector
//   grant     out SIZE  one-hot winner, or all zeros when no request is set
// -----------------------------------------------------------------------------
module static_priority_arbiter #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] requests,
    output logic [SIZE-1:0] grant
);

    // Two's-complement trick: r & -r isolates the lowest set bit.
    assign grant = requests & (~requests + SIZE'(1));

endmodule

// File: rtl/packet_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// packet_round_robin_arbiter
// Shares one valid/ready/last stream among SIZE requester channels, one whole
// packet at a time, with round-robin selection among valid channels. Once a
// beat is presented the grant is held until that packet's last beat is
// accepted, so packets never interleave and a stalled beat stays stable.
//
// Ports:
//   clock           in   clock
//   resetn          in   asynchronous active-low reset
//   requests_valid  in   SIZE             per-channel beat valid
//   requests_last   in   SIZE             per-channel last-beat flag
//   requests_data   in   SIZE*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   requests_ready  out  SIZE             per-channel beat accept
//   output_valid    out  1                forwarded beat valid
//   output_last     out  1                forwarded last flag
//   output_data     out  DATA_WIDTH       forwarded payload
//   output_ready    in   1                downstream accept
//   grant           out  SIZE             one-hot owner of the output, or zero
//   busy            out  1                registered, high while LOCKED
// -----------------------------------------------------------------------------
module packet_round_robin_arbiter #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [SIZE-1:0]            requests_valid,
    input  logic [SIZE-1:0]            requests_last,
    input  logic [SIZE*DATA_WIDTH-1:0] requests_data,
    output logic [SIZE-1:0]            requests_ready,
    output logic                       output_valid,
    output logic                       output_last,
    output logic [DATA_WIDTH-1:0]      output_data,
    input  logic                       output_ready,
    output logic [SIZE-1:0]            grant,
    output logic                       busy
);

    localparam int INDEX_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        mask_q, mask_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   busy_q, busy_d;

    logic [SIZE-1:0]        masked_requests;
    logic [SIZE-1:0]        masked_grant;
    logic [SIZE-1:0]        unmasked_grant;
    logic [SIZE-1:0]        arbiter_grant;
    logic [SIZE-1:0]        locked_grant;
    logic [SIZE-1:0]        completion_mask;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   accepted;

    // ---------------------------------------------------------------- arbitration
    assign masked_requests = requests_valid & mask_q;

    static_priority_arbiter #(.SIZE(SIZE)) u_masked_arbiter (
        .requests (masked_requests),
        .grant    (masked_grant)
    );

    static_priority_arbiter #(.SIZE(SIZE)) u_unmasked_arbiter (
        .requests (requests_valid),
        .grant    (unmasked_grant)
    );

    // Fall back to the unmasked set once every channel above the last
    // winner has been served (or none of them is requesting).
    assign arbiter_grant = (|masked_requests) ? masked_grant : unmasked_grant;

    // Locked grant is decoded from the captured index only, so other
    // channels toggling valid cannot disturb it.
    // Completion mask: ones strictly above the finishing channel, wrapping
    // to all ones when the top channel finishes.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_channel
            assign locked_grant[gi]    = (index_q == INDEX_WIDTH'(gi));
            assign completion_mask[gi] = (grant_index == INDEX_WIDTH'(SIZE - 1)) ||
                                         (INDEX_WIDTH'(gi) > grant_index);
        end
    endgenerate

    assign grant = (state_q == LOCKED) ? locked_grant : arbiter_grant;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        grant_index = '0;
        output_last = 1'b0;
        output_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (grant[i]) begin
                grant_index = INDEX_WIDTH'(i);
                output_last = requests_last[i];
                output_data = requests_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign output_valid   = |(grant & requests_valid);
    assign requests_ready = grant & {SIZE{output_ready}};
    assign accepted       = output_valid & output_ready;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (output_valid) begin
                    if (accepted && output_last) begin
                        // Single-beat packet: finish without ever locking.
                        mask_d = completion_mask;
                    end else begin
                        // Either a multi-beat packet started or the first beat
                        // stalled; both must hold the current owner.
                        state_d = LOCKED;
                        index_d = grant_index;
                    end
                end
            end
            LOCKED: begin
                if (accepted && output_last) begin
                    state_d = IDLE;
                    mask_d  = completion_mask;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            mask_q  <= '1;
            index_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            index_q <= index_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_packet_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_packet_round_robin_arbiter
// Directed bench for packet_round_robin_arbiter (SIZE=4, DATA_WIDTH=32).
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_packet_round_robin_arbiter;

    localparam int SIZE = 4;
    localparam int DW   = 32;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic [SIZE-1:0]      requests_valid;
    logic [SIZE-1:0]      requests_last;
    logic [SIZE*DW-1:0]   requests_data;
    logic [SIZE-1:0]      requests_ready;
    logic                 output_valid;
    logic                 output_last;
    logic [DW-1:0]        output_data;
    logic                 output_ready;
    logic [SIZE-1:0]      grant;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    packet_round_robin_arbiter #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .requests_valid (requests_valid),
        .requests_last  (requests_last),
        .requests_data  (requests_data),
        .requests_ready (requests_ready),
        .output_valid   (output_valid),
        .output_last    (output_last),
        .output_data    (output_data),
        .output_ready   (output_ready),
        .grant          (grant),
        .busy           (busy)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        requests_valid = v;
        requests_last  = l;
        output_ready   = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        requests_valid = '0;
        requests_last  = '0;
        output_ready   = 1'b0;
        resetn         = 1'b0;
        @(posedge clock);
        #2;
        resetn = 1'b1;
        tick();
    endtask

    function automatic logic [DW-1:0] chan_data(input int i);
        return 32'hC0DE_0000 + 32'(i * 16'h0111);
    endfunction

    initial begin
        logic [3:0] exp_grants [5];
        exp_grants[0] = 4'b0001;
        exp_grants[1] = 4'b0010;
        exp_grants[2] = 4'b0100;
        exp_grants[3] = 4'b1000;
        exp_grants[4] = 4'b0001;

        for (int i = 0; i < SIZE; i++) requests_data[i*DW +: DW] = chan_data(i);

        // ---------------- reset state and round-robin sweep
        do_reset();
        drive(4'b0000, 4'b0000, 1'b1);
        check_value("reset_grant", grant, 4'b0000);
        check_value("reset_ovalid", output_valid, 1'b0);
        check_value("reset_busy", busy, 1'b0);
        check_value("reset_rready", requests_ready, 4'b0000);
        drive(4'b1111, 4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check_value($sformatf("rr_grant_%0d", c), grant, exp_grants[c]);
            check_value($sformatf("rr_rready_%0d", c), requests_ready, exp_grants[c]);
            tick();
        end

        // ---------------- packet lock: ch0 three beats, ch1 waiting
        do_reset();
        for (int b = 1; b <= 3; b++) begin
            drive(4'b0011, {2'b00, 1'b1, (b == 3)}, 1'b1);
            check_value($sformatf("lock_grant_b%0d", b), grant, 4'b0001);
            check_value($sformatf("lock_ch1_ready_b%0d", b), requests_ready[1], 1'b0);
            check_value($sformatf("lock_last_b%0d", b), output_last, (b == 3));
            tick();
            if (b == 1) check_value("lock_busy_rise", busy, 1'b1);
        end
        drive(4'b0010, 4'b0010, 1'b1);
        check_value("lock_handoff_grant", grant, 4'b0010);
        check_value("lock_handoff_data", output_data, chan_data(1));
        check_value("lock_busy_fall", busy, 1'b0);
        tick();
        check_value("lock_busy_idle", busy, 1'b0);

        // ---------------- backpressure on first beat
        do_reset();
        drive(4'b0100, 4'b0100, 1'b0);
        check_value("bp_grant_c0", grant, 4'b0100);
        check_value("bp_ovalid_c0", output_valid, 1'b1);
        check_value("bp_rready_c0", requests_ready, 4'b0000);
        tick();
        drive(4'b0110, 4'b0110, 1'b0);
        check_value("bp_grant_c1", grant, 4'b0100);
        check_value("bp_data_c1", output_data, chan_data(2));
        check_value("bp_busy_c1", busy, 1'b1);
        tick();
        drive(4'b0110, 4'b0110, 1'b1);
        check_value("bp_grant_accept", grant, 4'b0100);
        check_value("bp_rready_accept", requests_ready, 4'b0100);
        tick();
        drive(4'b0010, 4'b0010, 1'b1);
        check_value("bp_next_grant", grant, 4'b0010);
        tick();

        // ---------------- valid drop mid-packet on ch3
        do_reset();
        drive(4'b1000, 4'b0000, 1'b1);
        check_value("drop_grant_start", grant, 4'b1000);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0001, 4'b0001, 1'b1);
            check_value($sformatf("drop_ovalid_%0d", c), output_valid, 1'b0);
            check_value($sformatf("drop_grant_%0d", c), grant, 4'b1000);
            tick();
        end
        drive(4'b1001, 4'b1001, 1'b1);
        check_value("drop_last_grant", grant, 4'b1000);
        check_value("drop_last_flag", output_last, 1'b1);
        check_value("drop_last_data", output_data, chan_data(3));
        tick();
        drive(4'b0001, 4'b0001, 1'b1);
        check_value("drop_ch0_grant", grant, 4'b0001);
        tick();

        // ---------------- wrap-around after channel 3
        do_reset();
        drive(4'b1001, 4'b1001, 1'b1);
        check_value("wrap_first", grant, 4'b0001);
        tick();
        check_value("wrap_ch3", grant, 4'b1000);
        tick();
        check_value("wrap_back_ch0", grant, 4'b0001);
        check_value("wrap_busy", busy, 1'b0);
        tick();

        // ---------------- reset mid-packet on ch2
        do_reset();
        drive(4'b0100, 4'b0000, 1'b1);
        check_value("rmid_grant_start", grant, 4'b0100);
        tick();
        drive(4'b0110, 4'b0000, 1'b1);
        check_value("rmid_busy_before", busy, 1'b1);
        check_value("rmid_grant_before", grant, 4'b0100);
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        #1;
        check_value("rmid_grant_after", grant, 4'b0010);
        check_value("rmid_busy_after", busy, 1'b0);
        check_value("rmid_data_after", output_data, chan_data(1));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
